// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: one outstanding I-mem read, a one-entry output buffer
// toward the IDU, and static backward-taken branch prediction.
module ysyx_23060203_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_data
);

  localparam logic [0:0] REQ  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  logic        redirect;
  logic [31:0] target;
  logic        req_fire;
  logic        resp_fire;
  logic        is_bwd_branch;
  logic [31:0] imm_b;
  logic [31:0] pred_pc;

  assign redirect       = flush | jump_flush;
  assign target         = (flush ? flush_dnpc : jump_dnpc) & ~32'h1;
  assign mem_req_valid  = (state_q == REQ);
  assign mem_req_addr   = {fetch_pc_q[31:2], 2'b00};
  // A response owed to a squashed fetch is always sunk, even with a full buffer.
  assign mem_resp_ready = drop_q | ~valid_q | out_ready;
  assign req_fire       = mem_req_valid & mem_req_ready;
  assign resp_fire      = (state_q == WAIT) & mem_resp_valid & mem_resp_ready;

  assign imm_b = {{19{mem_resp_data[31]}}, mem_resp_data[31], mem_resp_data[7],
                  mem_resp_data[30:25], mem_resp_data[11:8], 1'b0};
  assign is_bwd_branch = (mem_resp_data[6:0] == 7'b1100011) & mem_resp_data[31];
  assign pred_pc       = fetch_pc_q + (is_bwd_branch ? imm_b : 32'd4);

  assign out_valid = valid_q & ~flush;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    inst_d     = inst_q;

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
          if (redirect) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (resp_fire) begin
          state_d = REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            pc_d       = fetch_pc_q;
            inst_d     = mem_resp_data;
            valid_d    = 1'b1;
            fetch_pc_d = pred_pc;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = REQ;
    endcase

    // Redirect squashes the buffered instruction regardless of out_ready.
    if (redirect) begin
      fetch_pc_d = target;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      pc_q       <= 32'h0;
      inst_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Bench for ysyx_23060203_ifu: memory responder with controllable handshakes and an
// output scoreboard of expected (pc, inst) pairs.
module tb_ysyx_23060203_ifu;
  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_dnpc;
  logic        jump_flush;
  logic [31:0] jump_dnpc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t        sb_q[$];
  logic [31:0] req_log[$];

  bit          req_en = 1'b0;
  bit          resp_en = 1'b0;
  bit          pend;
  logic [31:0] paddr;

  always #5 clock = ~clock;

  ysyx_23060203_ifu #(.RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .flush_dnpc     (flush_dnpc),
    .jump_flush     (jump_flush),
    .jump_dnpc      (jump_dnpc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h3000_0010) return 32'hFE00_0EE3;      // beq x0,x0,-4
    else if (a == 32'h3000_0020) return 32'h0000_0463; // beq x0,x0,+8
    else return {a[27:0], 4'h3};                       // never a branch opcode
  endfunction

  assign mem_req_ready  = req_en;
  assign mem_resp_valid = pend & resp_en;
  assign mem_resp_data  = pend ? mem_word(paddr) : 32'h0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (pend && resp_en && mem_resp_ready) pend <= 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        pend  <= 1'b1;
        paddr <= mem_req_addr;
        req_log.push_back(mem_req_addr);
      end
    end
  end

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (mem_req_valid && mem_req_ready) begin
        checks++;
        if (pend) begin
          failures++;
          $display("FAIL single_outstanding: request addr=%h issued while one is pending",
                   mem_req_addr);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: got pc=%h inst=%h, required no output", out_pc, out_inst);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (out_pc !== e.pc || out_inst !== e.inst) begin
            failures++;
            $display("FAIL sb_output: got pc=%h inst=%h, required pc=%h inst=%h",
                     out_pc, out_inst, e.pc, e.inst);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.inst = mem_word(pc);
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input bit rq, input bit rs);
    reset = 1'b1;
    flush = 1'b0;
    jump_flush = 1'b0;
    flush_dnpc = 32'h0;
    jump_dnpc = 32'h0;
    out_ready = 1'b1;
    req_en = rq;
    resp_en = rs;
    repeat (2) step();
    sb_q.delete();
    req_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_reqs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    repeat (3) step();
  endtask

  task automatic wait_out_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    jump_flush = 1'b0;
    flush_dnpc = 32'h0;
    jump_dnpc = 32'h0;
    out_ready = 1'b1;
    req_en = 1'b1;
    resp_en = 1'b1;
    @(negedge clock);
    checks += 5;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    if (out_pc !== 32'h0) begin
      failures++; $display("FAIL reset_out_pc: got %h required 0", out_pc);
    end
    if (out_inst !== 32'h0) begin
      failures++; $display("FAIL reset_out_inst: got %h required 0", out_inst);
    end
    if (mem_resp_ready !== 1'b1) begin
      failures++; $display("FAIL reset_resp_ready: got %b required 1", mem_resp_ready);
    end
    if (mem_req_addr !== RESET_PC) begin
      failures++; $display("FAIL reset_addr: got %h required %h", mem_req_addr, RESET_PC);
    end
    step();
    sb_q.delete();
    req_log.delete();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL first_req: got valid=%b addr=%h required valid=1 addr=%h",
               mem_req_valid, mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push_exp(RESET_PC + 32'(4 * i));
    wait_reqs(3, ok);
    req_en = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL seq_reqs: got timeout required 3 requests"); end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL seq_drain: got %0d pending required 0", sb_q.size()); end
    checks++;
    if (req_log.size() != 3) begin
      failures++; $display("FAIL seq_count: got %0d requests required 3", req_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_log[i] !== RESET_PC + 32'(4 * i)) begin
          failures++;
          $display("FAIL seq_addr%0d: got %h required %h", i, req_log[i], RESET_PC + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backward_branch();
    bit ok;
    logic [31:0] exp_addr [7];
    exp_addr = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 32'h3000_000C,
                 32'h3000_0010, 32'h3000_000C, 32'h3000_0010};
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) push_exp(exp_addr[i]);
    wait_reqs(7, ok);
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bwd_drain: got %0d pending required 0", sb_q.size()); end
    for (int i = 4; i < 7; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== exp_addr[i]) begin
        failures++;
        $display("FAIL bwd_addr%0d: got %h required %h", i,
                 (req_log.size() > i) ? req_log[i] : 32'hx, exp_addr[i]);
      end
    end
  endtask

  task automatic test_forward_branch();
    bit ok;
    do_reset(1'b0, 1'b1);
    jump_flush = 1'b1;
    jump_dnpc = 32'h3000_0020;
    step();
    jump_flush = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0020) begin
      failures++;
      $display("FAIL req_redirect: got valid=%b addr=%h required valid=1 addr=30000020",
               mem_req_valid, mem_req_addr);
    end
    step();
    push_exp(32'h3000_0020);
    push_exp(32'h3000_0024);
    req_en = 1'b1;
    wait_reqs(2, ok);
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fwd_drain: got %0d pending required 0", sb_q.size()); end
    checks++;
    if (req_log.size() < 2 || req_log[1] !== 32'h3000_0024) begin
      failures++;
      $display("FAIL fwd_addr: got %h required 30000024", (req_log.size() > 1) ? req_log[1] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(1'b0, 1'b1);
    jump_flush = 1'b1;
    jump_dnpc = 32'hFFFF_FFFC;
    step();
    jump_flush = 1'b0;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    req_en = 1'b1;
    wait_reqs(2, ok);
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_drain: got %0d pending required 0", sb_q.size()); end
    checks++;
    if (req_log.size() < 2 || req_log[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_addr: got %h required 00000000", (req_log.size() > 1) ? req_log[1] : 32'hx);
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset(1'b1, 1'b1);
    out_ready = 1'b0;
    push_exp(RESET_PC);
    push_exp(RESET_PC + 32'd4);
    wait_out_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_fill: got out_valid=0 required 1"); end
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_inst !== mem_word(RESET_PC)
          || mem_resp_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h rr=%b required v=1 pc=%h inst=%h rr=0",
                 i, out_valid, out_pc, out_inst, mem_resp_ready, RESET_PC, mem_word(RESET_PC));
      end
    end
    checks++;
    if (req_log.size() != 2) begin
      failures++; $display("FAIL stall_reqs: got %0d requests required 2", req_log.size());
    end
    step();
    out_ready = 1'b1;
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_resume: got %0d pending required 0", sb_q.size()); end
  endtask

  task automatic test_jump_wait();
    bit ok;
    do_reset(1'b1, 1'b0);
    wait_reqs(1, ok);
    jump_flush = 1'b1;
    jump_dnpc = 32'h3000_0101;
    step();
    jump_flush = 1'b0;
    resp_en = 1'b1;
    req_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL jw_dropped%0d: got out_valid=%b required 0", i, out_valid);
      end
      if (i < 2) step();
    end
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0100) begin
      failures++;
      $display("FAIL jw_addr: got valid=%b addr=%h required valid=1 addr=30000100",
               mem_req_valid, mem_req_addr);
    end
    step();
    push_exp(32'h3000_0100);
    req_en = 1'b1;
    wait_reqs(2, ok);
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL jw_drain: got %0d pending required 0", sb_q.size()); end
  endtask

  task automatic test_flush_both();
    bit ok;
    do_reset(1'b1, 1'b1);
    out_ready = 1'b0;
    wait_out_valid(ok);
    resp_en = 1'b0;
    step();
    flush = 1'b1;
    jump_flush = 1'b1;
    flush_dnpc = 32'h8000_0000;
    jump_dnpc = 32'h3000_0040;
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL fl_force: got out_valid=%b required 0", out_valid);
    end
    step();
    flush = 1'b0;
    jump_flush = 1'b0;
    resp_en = 1'b1;
    req_en = 1'b0;
    @(negedge clock);
    step();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL fl_target: got v=%b rv=%b addr=%h required v=0 rv=1 addr=80000000",
               out_valid, mem_req_valid, mem_req_addr);
    end
    step();
    push_exp(32'h8000_0000);
    req_en = 1'b1;
    wait_reqs(3, ok);
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fl_drain: got %0d pending required 0", sb_q.size()); end
  endtask

  task automatic test_redirect_with_resp();
    bit ok;
    do_reset(1'b1, 1'b0);
    wait_reqs(1, ok);
    resp_en = 1'b1;
    jump_flush = 1'b1;
    jump_dnpc = 32'h3000_0200;
    req_en = 1'b0;
    step();
    jump_flush = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0200
        || mem_resp_ready !== 1'b1) begin
      failures++;
      $display("FAIL rr_state: got v=%b rv=%b addr=%h rr=%b required v=0 rv=1 addr=30000200 rr=1",
               out_valid, mem_req_valid, mem_req_addr, mem_resp_ready);
    end
    step();
    push_exp(32'h3000_0200);
    req_en = 1'b1;
    wait_reqs(2, ok);
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rr_drain: got %0d pending required 0", sb_q.size()); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    do_reset(1'b1, 1'b1);
    push_exp(RESET_PC);
    push_exp(RESET_PC + 32'd4);
    wait_reqs(3, ok);
    resp_en = 1'b0;
    #2 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL rw_reset: got v=%b rv=%b addr=%h required v=0 rv=1 addr=%h",
               out_valid, mem_req_valid, mem_req_addr, RESET_PC);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL rw_pre: got %0d pending required 0", sb_q.size());
    end
    step();
    sb_q.delete();
    req_log.delete();
    resp_en = 1'b1;
    reset = 1'b0;
    push_exp(RESET_PC);
    wait_reqs(1, ok);
    req_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rw_drain: got %0d pending required 0", sb_q.size()); end
    checks++;
    if (req_log.size() < 1 || req_log[0] !== RESET_PC) begin
      failures++;
      $display("FAIL rw_addr: got %h required %h", (req_log.size() > 0) ? req_log[0] : 32'hx, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backward_branch();
    test_forward_branch();
    test_wrap();
    test_stall();
    test_jump_wait();
    test_flush_both();
    test_redirect_with_resp();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1);
  end

endmodule
